// File: rtl/claw_pkg.sv
// Shared encodings for the two-axis claw scheduler: command values, scheduler states,
// button/limit indices and the per-axis command update rule. Homing states exist only with CLAW_HOMING_EN.
package claw_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_POS  = 2'd1,
    CMD_NEG  = 2'd2
  } cmd_e;

`ifdef CLAW_HOMING_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_X,
    ST_RUN_Y,
    ST_HOME_X,
    ST_HOME_Y
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_X,
    ST_RUN_Y
  } state_e;
`endif

  localparam int BTN_XP = 0;
  localparam int BTN_XN = 1;
  localparam int BTN_YP = 2;
  localparam int BTN_YN = 3;
  localparam int LIM_X  = 0;
  localparam int LIM_Y  = 1;

  // Button edges toggle the command; with no edge, hitting either travel end parks the axis.
  function automatic cmd_e cmd_next(input cmd_e cmd, input logic p_edge, input logic m_edge,
                                    input logic at_home, input logic at_max);
    if (p_edge && m_edge) return CMD_IDLE;
    if (p_edge)           return (cmd == CMD_POS) ? CMD_IDLE : CMD_POS;
    if (m_edge)           return (cmd == CMD_NEG) ? CMD_IDLE : CMD_NEG;
    if (cmd == CMD_NEG && at_home) return CMD_IDLE;
    if (cmd == CMD_POS && at_max)  return CMD_IDLE;
    return cmd;
  endfunction

endpackage

// File: rtl/claw_axis_scheduler_if.sv
// Signal bundle between the claw scheduler and its surroundings (buttons, switches, drivers).
interface claw_axis_scheduler_if #(
  parameter int POS_W = 12
) ();
  logic             step_tick;
  logic [3:0]       rf_db;
  logic [1:0]       limit_sw;
  logic             en_x;
  logic             dir_x;
  logic             en_y;
  logic             dir_y;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic             homing;

  modport slave (
    input  step_tick, rf_db, limit_sw,
    output en_x, dir_x, en_y, dir_y, pos_x, pos_y, homing
  );

  modport master (
    output step_tick, rf_db, limit_sw,
    input  en_x, dir_x, en_y, dir_y, pos_x, pos_y, homing
  );
endinterface

// File: rtl/claw_edge_detect.sv
// Four-bit rising-edge detector; the history register loads the live inputs during reset
// so a button already held at reset release is not seen as a press.
module claw_edge_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  output logic [3:0] rise
);
  logic [3:0] prev_q, prev_d;

  always_comb begin
    prev_d = din;
    rise   = din & ~prev_q;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= din;
    else      prev_q <= prev_d;
  end
endmodule

// File: rtl/claw_axis_scheduler.sv
// Time-sliced X/Y step scheduler for the claw: button-driven axis commands, soft travel limits,
// fair slice arbitration and, with CLAW_HOMING_EN defined, a homing sequence after reset.
module claw_axis_scheduler #(
  parameter int POS_W   = 12,
  parameter int MAX_POS = 2000,
  parameter int SLICE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  claw_axis_scheduler_if.slave  io
);
  import claw_pkg::*;

  localparam int               SL_W    = $clog2(SLICE + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
  localparam logic [SL_W-1:0]  SL_FULL = SL_W'(SLICE);

  cmd_e             cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [SL_W-1:0]  slice_q, slice_d;
  logic             last_x_q, last_x_d;

  logic [3:0] btn_rise;
  logic       home_x, home_y, homing;
  logic       x_act, y_act, en_x, en_y, dir_x, dir_y;
  logic       grant_chg, running;

  claw_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (io.rf_db),
    .rise (btn_rise)
  );

`ifdef CLAW_HOMING_EN
  localparam state_e RST_STATE = ST_HOME_X;
  assign home_x = (state_q == ST_HOME_X);
  assign home_y = (state_q == ST_HOME_Y);
`else
  localparam state_e RST_STATE = ST_IDLE;
  assign home_x = 1'b0;
  assign home_y = 1'b0;
`endif

  assign homing    = home_x | home_y;
  assign x_act     = (cmd_x_q != CMD_IDLE);
  assign y_act     = (cmd_y_q != CMD_IDLE);
  assign en_x      = (state_q == ST_RUN_X) | home_x;
  assign en_y      = (state_q == ST_RUN_Y) | home_y;
  assign dir_x     = (cmd_x_q == CMD_POS);
  assign dir_y     = (cmd_y_q == CMD_POS);
  assign running   = (state_q == ST_RUN_X) | (state_q == ST_RUN_Y);
  assign grant_chg = (state_d != state_q);

  // Saturating move; zeroing at the home switch takes priority over any step.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos, input logic zero,
                                                input logic step, input logic dir);
    if (zero)                         return '0;
    if (step && dir && pos < POS_MAX) return pos + POS_W'(1);
    if (step && !dir && pos != '0)    return pos - POS_W'(1);
    return pos;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (x_act && y_act) state_d = last_x_q ? ST_RUN_Y : ST_RUN_X;
        else if (x_act)     state_d = ST_RUN_X;
        else if (y_act)     state_d = ST_RUN_Y;
      end
      ST_RUN_X: begin
        if (!x_act)                          state_d = y_act ? ST_RUN_Y : ST_IDLE;
        else if (slice_q == SL_FULL && y_act) state_d = ST_RUN_Y;
      end
      ST_RUN_Y: begin
        if (!y_act)                          state_d = x_act ? ST_RUN_X : ST_IDLE;
        else if (slice_q == SL_FULL && x_act) state_d = ST_RUN_X;
      end
`ifdef CLAW_HOMING_EN
      ST_HOME_X: if (io.limit_sw[LIM_X]) state_d = ST_HOME_Y;
      ST_HOME_Y: if (io.limit_sw[LIM_Y]) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_x_d = cmd_next(cmd_x_q, btn_rise[BTN_XP] & ~homing, btn_rise[BTN_XN] & ~homing,
                       io.limit_sw[LIM_X], pos_x_q == POS_MAX);
    cmd_y_d = cmd_next(cmd_y_q, btn_rise[BTN_YP] & ~homing, btn_rise[BTN_YN] & ~homing,
                       io.limit_sw[LIM_Y], pos_y_q == POS_MAX);

    // A tick that lands on a grant change belongs to neither axis.
    pos_x_d = pos_next(pos_x_q, io.limit_sw[LIM_X] & ((cmd_x_q == CMD_NEG) | home_x),
                       io.step_tick & en_x & ~grant_chg, dir_x);
    pos_y_d = pos_next(pos_y_q, io.limit_sw[LIM_Y] & ((cmd_y_q == CMD_NEG) | home_y),
                       io.step_tick & en_y & ~grant_chg, dir_y);

    slice_d = slice_q;
    if (grant_chg || !running)                 slice_d = '0;
    else if (io.step_tick && slice_q != SL_FULL) slice_d = slice_q + SL_W'(1);

    last_x_d = last_x_q;
    if (grant_chg && state_d == ST_RUN_X) last_x_d = 1'b1;
    if (grant_chg && state_d == ST_RUN_Y) last_x_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_x_q  <= CMD_IDLE;
      cmd_y_q  <= CMD_IDLE;
      state_q  <= RST_STATE;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      slice_q  <= '0;
      last_x_q <= 1'b0;
    end else begin
      cmd_x_q  <= cmd_x_d;
      cmd_y_q  <= cmd_y_d;
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      slice_q  <= slice_d;
      last_x_q <= last_x_d;
    end
  end

  assign io.en_x   = en_x;
  assign io.en_y   = en_y;
  assign io.dir_x  = dir_x;
  assign io.dir_y  = dir_y;
  assign io.pos_x  = pos_x_q;
  assign io.pos_y  = pos_y_q;
  assign io.homing = homing;
endmodule

// File: tb/tb_claw_axis_scheduler.sv
// Directed bench for claw_axis_scheduler: jog, limits, slice arbitration and reset behaviour.
module tb_claw_axis_scheduler;
  localparam int POS_W   = 12;
  localparam int MAX_POS = 2000;
  localparam int SLICE   = 16;
`ifdef CLAW_HOMING_EN
  localparam logic HOM = 1'b1;
`else
  localparam logic HOM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  claw_axis_scheduler_if #(.POS_W(POS_W)) bus ();

  claw_axis_scheduler #(.POS_W(POS_W), .MAX_POS(MAX_POS), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  logic rec = 1'b0;
  int   overlap = 0;
  int   n_g = 0;
  int   last_g = 0;
  int   gseq [8];

  always @(negedge clk) begin
    int g;
    if (bus.en_x && bus.en_y) overlap++;
    g = bus.en_x ? 1 : (bus.en_y ? 2 : 0);
    if (!rec) last_g = 0;
    else if (g != 0 && g != last_g) begin
      if (n_g < 8) gseq[n_g] = g;
      n_g++;
      last_g = g;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] btns);
    bus.rf_db = btns;
    cyc(1);
    bus.rf_db = 4'b0000;
    cyc(1);
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      bus.step_tick = 1'b1;
      cyc(1);
      bus.step_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic finish_homing();
`ifdef CLAW_HOMING_EN
    bus.limit_sw = 2'b01;
    cyc(1);
    bus.limit_sw = 2'b10;
    cyc(1);
    bus.limit_sw = 2'b00;
    cyc(1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    finish_homing();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.step_tick = 1'b0;
    bus.rf_db     = 4'b0000;
    bus.limit_sw  = 2'b00;

    // Reset state
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("rst_en_x",   bus.en_x,   HOM);
    check("rst_dir_x",  bus.dir_x,  0);
    check("rst_en_y",   bus.en_y,   0);
    check("rst_dir_y",  bus.dir_y,  0);
    check("rst_pos_x",  bus.pos_x,  0);
    check("rst_pos_y",  bus.pos_y,  0);
    check("rst_homing", bus.homing, HOM);
    finish_homing();

    // X+ jog: five steps, then toggle off
    press(4'b0001);
    check("jog_en_x",  bus.en_x,  1);
    check("jog_dir_x", bus.dir_x, 1);
    check("jog_en_y",  bus.en_y,  0);
    steps(5);
    check("jog_pos_x", bus.pos_x, 5);
    press(4'b0001);
    check("jog_stop_en_x", bus.en_x, 0);
    steps(2);
    check("jog_hold_pos_x", bus.pos_x, 5);

    // X- down to 3, then home switch hit on the second step
    press(4'b0010);
    check("neg_en_x",  bus.en_x,  1);
    check("neg_dir_x", bus.dir_x, 0);
    steps(2);
    check("neg_pos_x", bus.pos_x, 3);
    steps(1);
    bus.step_tick    = 1'b1;
    bus.limit_sw[0]  = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
    check("lim_pos_x", bus.pos_x, 0);
    cyc(1);
    check("lim_en_x", bus.en_x, 0);
    bus.limit_sw = 2'b00;
    cyc(1);

    // Both axes active: slices alternate X, Y, X over 40 ticks
    do_reset();
    press(4'b0101);
    rec = 1'b1;
    steps(40);
    rec = 1'b0;
    check("arb_grants", n_g, 3);
    check("arb_g0", gseq[0], 1);
    check("arb_g1", gseq[1], 2);
    check("arb_g2", gseq[2], 1);
    check("arb_pos_x", bus.pos_x, 24);
    check("arb_pos_y", bus.pos_y, 16);
    press(4'b0101);
    check("arb_stop_en", {bus.en_x, bus.en_y}, 0);

    // Reset mid-slice in RUN_Y, with X+ held through reset release
    press(4'b0100);
    steps(5);
    check("mid_pos_y", bus.pos_y, 21);
    bus.rf_db = 4'b0001;
    rst = 1'b0;
    cyc(1);
    check("mid_rst_en_y",  bus.en_y,  0);
    check("mid_rst_pos_y", bus.pos_y, 0);
    check("mid_rst_pos_x", bus.pos_x, 0);
    check("mid_rst_en_x",  bus.en_x,  HOM);
    rst = 1'b1;
    cyc(2);
    finish_homing();
    check("held_btn_no_edge", bus.en_x, 0);
    bus.rf_db = 4'b0000;
    cyc(1);

    // Upper soft limit
    press(4'b0001);
    bus.step_tick = 1'b1;
    cyc(MAX_POS - 1);
    bus.step_tick = 1'b0;
    press(4'b0001);
    check("max_m1_pos_x", bus.pos_x, MAX_POS - 1);
    press(4'b0001);
    steps(3);
    check("max_pos_x", bus.pos_x, MAX_POS);
    check("max_en_x",  bus.en_x,  0);

    check("no_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
